// File: rtl/lc3_mux_pkg.sv
// ----------------------------------------------------------------------------
// lc3_mux_pkg
//   Shared definitions for the LC-3 datapath select/forwarding muxes.
//   - N_MAX       : largest channel count the select muxes are built for.
//   - clog2_min1  : index width for an n-way select, never less than 1 bit
//                   so that a 1- or 2-channel mux still has a usable index.
// ----------------------------------------------------------------------------
package lc3_mux_pkg;

    localparam int N_MAX = 16;

    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : lc3_mux_pkg

// File: rtl/prio_enc.sv
// ----------------------------------------------------------------------------
// prio_enc
//   Highest-index-wins priority encoder for the channel selects of an N-way
//   mux. Select bit i-1 belongs to channel i; channel 0 has no select and is
//   reported when no select bit is set.
//
// Ports
//   sel    in   [N-2:0]        select bits for channels 1..N-1
//   idx    out  [IDX_W-1:0]    winning channel (0 when no select is set)
//   hit    out  1              at least one select bit is set
//   multi  out  1              more than one select bit is set
// ----------------------------------------------------------------------------
module prio_enc
    import lc3_mux_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic [N-2:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             hit,
    output logic             multi
);

    logic [N-2:0] w_sel_m1;

    // Ascending scan: a later (higher) set bit overwrites an earlier one,
    // so the highest-index select ends up in idx.
    always_comb begin
        idx = '0;
        for (int i = 1; i < N; i++) begin
            if (sel[i-1]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something behind only if at least
    // two bits were set.
    assign w_sel_m1 = sel - (N-1)'(1);
    assign hit      = |sel;
    assign multi    = |(sel & w_sel_m1);

endmodule : prio_enc

// File: rtl/prio_sel_pipe.sv
// ----------------------------------------------------------------------------
// prio_sel_pipe
//   N-way priority select with a registered output stage, used at pipeline
//   boundaries of the LC-3 datapath for operand/forwarding selection. The
//   highest-index asserted select wins; with no select the result is
//   channel 0, or (STICKY != 0) the value already held in the output stage.
//   The output stage honours stall and flush, reports the winning channel,
//   flags captures that saw more than one select and counts them in a
//   saturating counter. Every output comes straight from a register.
//
// Parameters
//   WIDTH   data width of each channel and of out
//   N       channel count, 2..16
//   STICKY  0: no select -> in_data[0]; otherwise no select -> hold out/src_idx
//   CNT_W   width of the saturating conflict counter
//
// Ports
//   clk           in   1                rising-edge clock
//   reset         in   1                synchronous, active-high
//   sel           in   [N-2:0]          bit i-1 selects channel i
//   in_data       in   [N-1:0][WIDTH]   channel data, channel i = in_data[i]
//   valid_in      in   1                sel/in_data qualify this cycle
//   stall         in   1                hold the output stage
//   flush         in   1                kill the output stage (beats stall)
//   out           out  [WIDTH-1:0]      registered selected data
//   valid_out     out  1                out holds a live captured value
//   src_idx       out  [IDX_W-1:0]      registered winning channel
//   conflict      out  1                >1 select set at the last capture
//   conflict_cnt  out  [CNT_W-1:0]      saturating count of such captures
// ----------------------------------------------------------------------------
module prio_sel_pipe
    import lc3_mux_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int N      = 8,
    parameter int STICKY = 0,
    parameter int CNT_W  = 8,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-2:0]              sel,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    input  logic                      valid_in,
    input  logic                      stall,
    input  logic                      flush,
    output logic [WIDTH-1:0]          out,
    output logic                      valid_out,
    output logic [IDX_W-1:0]          src_idx,
    output logic                      conflict,
    output logic [CNT_W-1:0]          conflict_cnt
);

    logic [IDX_W-1:0] w_win;
    logic             w_hit;
    logic             w_multi;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_next_out;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_keep;
    logic             w_cnt_sat;

    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_conflict;
    logic [CNT_W-1:0] r_cnt;

    prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .sel   (sel),
        .idx   (w_win),
        .hit   (w_hit),
        .multi (w_multi)
    );

    assign w_sel_data = in_data[w_win];

    // In sticky mode an empty select re-captures the current output stage,
    // so a valid capture with no select leaves out/src_idx where they are.
    assign w_keep     = (STICKY != 0) && !w_hit;
    assign w_next_out = w_keep ? r_out : w_sel_data;
    assign w_next_idx = w_keep ? r_idx : w_win;

    assign w_cnt_sat  = &r_cnt;

    // Output stage: reset > flush > stall > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_conflict <= 1'b0;
            r_cnt      <= '0;
        end else if (flush) begin
            // Only the qualifiers die; data, index and count stay for debug.
            r_valid    <= 1'b0;
            r_conflict <= 1'b0;
        end else if (!stall) begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_out      <= w_next_out;
                r_idx      <= w_next_idx;
                r_conflict <= w_multi;
                if (w_multi && !w_cnt_sat) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_conflict <= 1'b0;
            end
        end
    end

    assign out          = r_out;
    assign valid_out    = r_valid;
    assign src_idx      = r_idx;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;

endmodule : prio_sel_pipe
